// File: rtl/proc_pkg.sv
// Shared types and sizes for the lab6 processor control path.
// Instruction format is IIIXXXYYY: opcode, destination Rx, source Ry.
package proc_pkg;

    localparam int DATA_W = 9;
    localparam int NREG   = 8;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MVF = 3'b100
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_ctrl_dec3to8.sv
// 3-bit to 8-bit one-hot decoder with enable; used for the Rx and Ry register fields.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'd0;
        if (en) y = 8'd1 << w;
    end

endmodule

// File: rtl/proc_ctrl.sv
// Step sequencer for the lab6 datapath: captures IR in T0, then drives one-hot bus
// selects and register load enables for T1..T3, pulsing Done on the final step.
module proc_ctrl #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int NREG   = proc_pkg::NREG
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [DATA_W-1:0] IR,
    output logic [NREG-1:0]   Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              GFout,
    output logic [NREG-1:0]   Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);
    import proc_pkg::*;

    state_t     state, state_nxt;
    logic [2:0] op;
    logic [7:0] dec_x, dec_y;
    logic       sel_rx, sel_ry, ld_rx;

    assign op = IR[8:6];

    dec3to8 u_dec_x (.w(IR[5:3]), .en(!Reset), .y(dec_x));
    dec3to8 u_dec_y (.w(IR[2:0]), .en(!Reset), .y(dec_y));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            IR    <= '0;
        end else begin
            state <= state_nxt;
            if (state == T0 && Run) IR <= DIN;
        end
    end

    always_comb begin
        state_nxt = T0;
        IRin      = 1'b0;
        DINout    = 1'b0;
        Gout      = 1'b0;
        GFout     = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;
        sel_rx    = 1'b0;
        sel_ry    = 1'b0;
        ld_rx     = 1'b0;

        case (state)
            T0: begin
                if (Run) begin
                    IRin      = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV:  begin sel_ry = 1'b1; ld_rx = 1'b1; Done = 1'b1; end
                    OP_MVI: begin DINout = 1'b1; ld_rx = 1'b1; Done = 1'b1; end
                    OP_MVF: begin GFout  = 1'b1; ld_rx = 1'b1; Done = 1'b1; end
                    OP_ADD, OP_SUB: begin
                        sel_rx    = 1'b1;
                        Ain       = 1'b1;
                        state_nxt = T2;
                    end
                    default: Done = 1'b1;  // reserved opcodes retire as a NOP
                endcase
            end
            T2: begin
                sel_ry    = 1'b1;
                Gin       = 1'b1;
                AddSub    = (op == OP_SUB);
                state_nxt = T3;
            end
            T3: begin
                Gout  = 1'b1;
                ld_rx = 1'b1;
                Done  = 1'b1;
            end
            default: state_nxt = T0;
        endcase

        Rout = (sel_rx ? dec_x : 8'd0) | (sel_ry ? dec_y : 8'd0);
        Rin  = ld_rx ? dec_x : 8'd0;

        // Reset forces a quiet datapath in the same cycle, not only after the edge
        if (Reset) begin
            state_nxt = T0;
            IRin      = 1'b0;
            DINout    = 1'b0;
            Gout      = 1'b0;
            GFout     = 1'b0;
            Ain       = 1'b0;
            Gin       = 1'b0;
            AddSub    = 1'b0;
            Done      = 1'b0;
            Rout      = '0;
            Rin       = '0;
        end
    end

endmodule
